psw_store: RTL and testbench
============================

# psw_store

Password storage and comparison datapath for the door lock. It captures keypad digits into a stored-password memory (`mem`) or an entry buffer (`buff`) under the strobes issued by the lock controller. It returns the comparison and status flags the controller branches on: `same`, `master_same`, `limit` and `error_num`. It sits directly below the controller FSM: it consumes the controller's `mem_*`, `buff_*` and `decision` outputs and feeds the controller's condition inputs.

## Interface
- `MAX_LEN`, 8: digit capacity of `mem` and of `buff`.
- `MIN_LEN`, 4: minimum stored length for `same` to assert.
- `ERR_MAX`, 10: error count at which `lockout` asserts.
- `MASTER_LEN`, 8: length of the master password.
- `MASTER_PSW`, 32'h1234_5678: master digits; digit i sits at bits [4i+3:4i], with digit 0 entered first.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: one clock; reset is asynchronous and active-low (0 = reset).
- `digit_in` in 4: keypad digit 0–9, qualified by `input_valid`.
- `input_valid` in 1: one-cycle pulse when `digit_in` is valid.
- `mem_sl` in 1: write `digit_in` into `mem`.
- `buff_sl` in 1: write `digit_in` into `buff`.
- `mem_rst` in 1: clear `mem`.
- `buff_rst` in 1: clear `buff`.
- `decision` in 1: 1 selects `mem` as the `limit` source; 0 selects `buff`.
- `err_inc` in 1: failed unlock attempt, one-cycle pulse.
- `err_clr` in 1: clear the error counter.
- `same` out 1: `buff` equals `mem`.
- `master_same` out 1: `buff` equals the master password.
- `limit` out 1: the selected store is full.
- `error_num` out 4: failed-attempt count.
- `lockout` out 1: `error_num` ≥ `ERR_MAX`.
- `mem_len` out 4: number of digits held in `mem`.
- `buff_len` out 4: number of digits held in `buff`.

## Operation
- **Storage.** `mem` and `buff` are each `MAX_LEN`×4-bit registers with their own length counter. Digit k is written at slot k; unwritten slots hold 0.
- **`mem` write.** Occurs when `mem_sl & input_valid & (mem_len < MAX_LEN)`: slot `mem_len` takes `digit_in`, then `mem_len` increments.
- **`mem` write when full.** Ignored; no wrap-around and no change.
- **`buff` write.** Same rule, using `buff_sl` and `buff_len`. `mem` and `buff` writes in the same cycle are independent, so both occur.
- **Clear.** `mem_rst` synchronously zeroes all `mem` slots and `mem_len`. It overrides `mem_sl` in the same cycle. `buff_rst` acts the same way on `buff` and overrides `buff_sl`.
- **`same`.** Asserts when `mem_len == buff_len`, `mem_len ≥ MIN_LEN`, and every slot below `mem_len` matches.
- **`master_same`.** Asserts when `buff_len == MASTER_LEN` and `buff` equals `MASTER_PSW` slot-for-slot.
- **`limit`.** Equals `decision ? (mem_len == MAX_LEN) : (buff_len == MAX_LEN)`.
- **`error_num`.** Increments on `err_inc` and saturates at 15.
  - `err_clr` zeroes it and has priority over `err_inc`.
  - Neither `mem_rst` nor `buff_rst` affects it.
- **Out-of-range digits.** Values 10–15 are stored as given; filtering is the keypad decoder's job.

## Timing
- **Reset.** All storage, lengths and `error_num` go to 0 immediately on `rst` = 0.
  - Outputs after reset: `same`=0, `master_same`=0, `limit`=0, `lockout`=0, `mem_len`=0, `buff_len`=0.
  - Reset asserted mid-entry discards any partial entry.
- **Register updates.** Writes, clears and counter changes take effect at the rising edge where the strobe is sampled.
- **Flag latency.** `same`, `master_same`, `limit` and `lockout` are combinational from registers. They therefore reflect the edge that performed the write in the following cycle (latency 1 from `input_valid`).
- **No handshake.** Strobes are level-sampled every cycle. A strobe held for N cycles with `input_valid` high writes N digits.
- **`decision` switch.** Changing `decision` changes `limit` in the same cycle (combinational).

## Test plan
- **Match.** `mem_sl`: digits 1,2,3,4; then `buff_sl`: 1,2,3,4 → `same`=1 and `mem_len`=`buff_len`=4. One further `buff` digit 5 → `same`=0.
- **Short password.** `mem`=1,2,3 and `buff`=1,2,3 → `same`=0 (below `MIN_LEN`).
- **Full store.** With `decision`=1, write 8 digits into `mem` → `limit`=1. A 9th `input_valid` changes neither contents nor `mem_len`. `mem_rst` together with `mem_sl` in the same cycle → `mem_len`=0.
- **Master password.** `buff` 8,7,6,5,4,3,2,1 with the default `MASTER_PSW` → `master_same`=1 and `same`=0. Then `buff_rst` → `master_same`=0 and `buff_len`=0.
- **Error counter.** 10 `err_inc` pulses → `error_num`=10 and `lockout`=1. 7 more pulses → `error_num`=15. `err_clr` together with `err_inc` → `error_num`=0.
- **Async reset.** Assert `rst` low between clock edges after 3 `mem` digits → `mem_len`=0 and all flags 0 without waiting for an edge. After release, the next write lands in slot 0.

Source files
------------

// File: rtl/psw_store.sv
// Password storage and comparison datapath for the door lock: captures keypad
// digits into the stored password (mem) or entry buffer (buff) and flags matches.
module psw_store #(
    parameter int                      MAX_LEN    = 8,
    parameter int                      MIN_LEN    = 4,
    parameter int                      ERR_MAX    = 10,
    parameter int                      MASTER_LEN = 8,
    parameter logic [4*MASTER_LEN-1:0] MASTER_PSW = 32'h1234_5678
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_in,
    input  logic       input_valid,
    input  logic       mem_sl,
    input  logic       buff_sl,
    input  logic       mem_rst,
    input  logic       buff_rst,
    input  logic       decision,
    input  logic       err_inc,
    input  logic       err_clr,
    output logic       same,
    output logic       master_same,
    output logic       limit,
    output logic [3:0] error_num,
    output logic       lockout,
    output logic [3:0] mem_len,
    output logic [3:0] buff_len
);

    localparam logic [3:0] C_MAX_LEN    = 4'(MAX_LEN);
    localparam logic [3:0] C_MIN_LEN    = 4'(MIN_LEN);
    localparam logic [3:0] C_ERR_MAX    = 4'(ERR_MAX);
    localparam logic [3:0] C_MASTER_LEN = 4'(MASTER_LEN);

    logic [3:0] r_mem  [MAX_LEN];
    logic [3:0] r_buff [MAX_LEN];
    logic [3:0] r_mem_len;
    logic [3:0] r_buff_len;
    logic [3:0] r_err;

    logic w_mem_wr;
    logic w_buff_wr;
    logic w_slots_eq;
    logic w_master_eq;

    // A write into a full store is dropped rather than wrapping to slot 0.
    assign w_mem_wr  = mem_sl  & input_valid & (r_mem_len  < C_MAX_LEN);
    assign w_buff_wr = buff_sl & input_valid & (r_buff_len < C_MAX_LEN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the slots are reset too, because unwritten slots must read as 0.
            for (int k = 0; k < MAX_LEN; k++) r_mem[k] <= '0;
            r_mem_len <= '0;
        end else if (mem_rst) begin
            for (int k = 0; k < MAX_LEN; k++) r_mem[k] <= '0;
            r_mem_len <= '0;
        end else if (w_mem_wr) begin
            for (int k = 0; k < MAX_LEN; k++)
                if (r_mem_len == 4'(k)) r_mem[k] <= digit_in;
            r_mem_len <= r_mem_len + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < MAX_LEN; k++) r_buff[k] <= '0;
            r_buff_len <= '0;
        end else if (buff_rst) begin
            for (int k = 0; k < MAX_LEN; k++) r_buff[k] <= '0;
            r_buff_len <= '0;
        end else if (w_buff_wr) begin
            for (int k = 0; k < MAX_LEN; k++)
                if (r_buff_len == 4'(k)) r_buff[k] <= digit_in;
            r_buff_len <= r_buff_len + 4'd1;
        end
    end

    // Clear wins over increment; the count sticks at 15 instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= '0;
        end else if (err_clr) begin
            r_err <= '0;
        end else if (err_inc && (r_err != 4'hF)) begin
            r_err <= r_err + 4'd1;
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_slots_eq = 1'b1;
        for (int k = 0; k < MAX_LEN; k++)
            if ((4'(k) < r_mem_len) && (r_mem[k] != r_buff[k])) w_slots_eq = 1'b0;
    end

    always_comb begin
        w_master_eq = 1'b1;
        for (int k = 0; k < MASTER_LEN; k++)
            if (r_buff[k] != MASTER_PSW[4*k +: 4]) w_master_eq = 1'b0;
    end

    assign same        = (r_mem_len == r_buff_len) && (r_mem_len >= C_MIN_LEN) && w_slots_eq;
    assign master_same = (r_buff_len == C_MASTER_LEN) && w_master_eq;
    assign limit       = decision ? (r_mem_len == C_MAX_LEN) : (r_buff_len == C_MAX_LEN);
    assign lockout     = (r_err >= C_ERR_MAX);
    assign error_num   = r_err;
    assign mem_len     = r_mem_len;
    assign buff_len    = r_buff_len;

endmodule

// File: tb/tb_psw_store.sv
// Scoreboard bench for psw_store: directed stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_psw_store;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] digit_in;
    logic       input_valid, mem_sl, buff_sl, mem_rst, buff_rst;
    logic       decision, err_inc, err_clr;
    logic       same, master_same, limit, lockout;
    logic [3:0] error_num, mem_len, buff_len;

    psw_store dut (
        .clk(clk), .rst(rst), .digit_in(digit_in), .input_valid(input_valid),
        .mem_sl(mem_sl), .buff_sl(buff_sl), .mem_rst(mem_rst), .buff_rst(buff_rst),
        .decision(decision), .err_inc(err_inc), .err_clr(err_clr),
        .same(same), .master_same(master_same), .limit(limit),
        .error_num(error_num), .lockout(lockout),
        .mem_len(mem_len), .buff_len(buff_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       same;
        logic       master_same;
        logic       limit;
        logic       lockout;
        logic [3:0] error_num;
        logic [3:0] mem_len;
        logic [3:0] buff_len;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string name, input string field, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %0h, expected %0h", name, field, act, req);
        end
    endtask

    // Monitor: compares one pending expectation per falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.name, "same",        {3'b0, same},        {3'b0, e.same});
            cmp(e.name, "master_same", {3'b0, master_same}, {3'b0, e.master_same});
            cmp(e.name, "limit",       {3'b0, limit},       {3'b0, e.limit});
            cmp(e.name, "lockout",     {3'b0, lockout},     {3'b0, e.lockout});
            cmp(e.name, "error_num",   error_num,           e.error_num);
            cmp(e.name, "mem_len",     mem_len,             e.mem_len);
            cmp(e.name, "buff_len",    buff_len,            e.buff_len);
        end
    end

    task automatic expect_state(input string name, input logic s, input logic ms, input logic lim,
                                input logic lo, input int err, input int ml, input int bl);
        exp_t e;
        e.name = name; e.same = s; e.master_same = ms; e.limit = lim; e.lockout = lo;
        e.error_num = 4'(err); e.mem_len = 4'(ml); e.buff_len = 4'(bl);
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic apply(input logic ms, input logic bs, input logic mr, input logic br,
                         input logic ei, input logic ec, input logic v, input logic [3:0] d);
        mem_sl = ms; buff_sl = bs; mem_rst = mr; buff_rst = br;
        err_inc = ei; err_clr = ec; input_valid = v; digit_in = d;
        @(posedge clk);
        #1;
        mem_sl = 0; buff_sl = 0; mem_rst = 0; buff_rst = 0;
        err_inc = 0; err_clr = 0; input_valid = 0; digit_in = 0;
    endtask

    // Digit i of the sequence is digits[4i+3:4i]; digit 0 is entered first.
    task automatic write_seq(input logic to_mem, input logic to_buff, input logic [31:0] digits, input int n);
        for (int i = 0; i < n; i++) apply(to_mem, to_buff, 0, 0, 0, 0, 1, digits[4*i +: 4]);
    endtask

    task automatic pulse_err(input int n);
        for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 1, 0, 0, 4'd0);
    endtask

    initial begin
        rst = 0; decision = 0; digit_in = 0; input_valid = 0;
        mem_sl = 0; buff_sl = 0; mem_rst = 0; buff_rst = 0; err_inc = 0; err_clr = 0;
        repeat (2) @(negedge clk);
        #1;
        expect_state("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1;

        // Match, then one extra buff digit breaks it.
        write_seq(1, 0, 32'h0000_4321, 4);
        expect_state("mem4", 0, 0, 0, 0, 0, 4, 0);
        write_seq(0, 1, 32'h0000_4321, 4);
        expect_state("match", 1, 0, 0, 0, 0, 4, 4);
        write_seq(0, 1, 32'h0000_0005, 1);
        expect_state("extra_digit", 0, 0, 0, 0, 0, 4, 5);
        apply(0, 0, 1, 1, 0, 0, 0, 4'd0);
        expect_state("clear_both", 0, 0, 0, 0, 0, 0, 0);

        // Simultaneous writes to both stores.
        write_seq(1, 1, 32'h0000_1413, 4);
        expect_state("dual_write", 1, 0, 0, 0, 0, 4, 4);
        apply(0, 0, 1, 1, 0, 0, 0, 4'd0);

        // Below minimum length.
        write_seq(1, 0, 32'h0000_0321, 3);
        write_seq(0, 1, 32'h0000_0321, 3);
        expect_state("short", 0, 0, 0, 0, 0, 3, 3);
        apply(0, 0, 1, 1, 0, 0, 0, 4'd0);

        // Full store, limit selection, ignored 9th digit, clear over write.
        decision = 1;
        write_seq(1, 0, 32'h8765_4321, 8);
        expect_state("mem_full", 0, 0, 1, 0, 0, 8, 0);
        decision = 0;
        expect_state("limit_buff_sel", 0, 0, 0, 0, 0, 8, 0);
        decision = 1;
        write_seq(0, 1, 32'h8765_4321, 8);
        expect_state("match8", 1, 0, 1, 0, 0, 8, 8);
        write_seq(1, 0, 32'h0000_0009, 1);
        expect_state("mem_ninth", 1, 0, 1, 0, 0, 8, 8);
        apply(1, 0, 1, 0, 0, 0, 1, 4'd9);
        expect_state("rst_over_sl", 0, 0, 0, 0, 0, 0, 8);
        apply(0, 0, 0, 1, 0, 0, 0, 4'd0);
        decision = 0;

        // Master password.
        write_seq(0, 1, 32'h1234_5678, 8);
        expect_state("master", 0, 1, 1, 0, 0, 0, 8);
        apply(0, 0, 0, 1, 0, 0, 0, 4'd0);
        expect_state("master_clr", 0, 0, 0, 0, 0, 0, 0);

        // Error counter.
        pulse_err(9);
        expect_state("err9", 0, 0, 0, 0, 9, 0, 0);
        pulse_err(1);
        expect_state("err10", 0, 0, 0, 1, 10, 0, 0);
        pulse_err(7);
        expect_state("err_sat", 0, 0, 0, 1, 15, 0, 0);
        apply(0, 0, 1, 1, 0, 0, 0, 4'd0);
        expect_state("err_keep", 0, 0, 0, 1, 15, 0, 0);
        apply(0, 0, 0, 0, 1, 1, 0, 4'd0);
        expect_state("err_clr", 0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset between edges mid-entry.
        pulse_err(2);
        write_seq(1, 0, 32'h0000_0321, 3);
        #2;
        rst = 0;
        expect_state("async_rst", 0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        write_seq(1, 0, 32'h0000_8765, 4);
        write_seq(0, 1, 32'h0000_8765, 4);
        expect_state("after_rst", 1, 0, 0, 0, 0, 4, 4);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
